cache_bus_arbiter: RTL

//  Shares one cache-line memory bus controller between N_REQ caches (I$, D$, ...).

---
 rtl/cache_bus_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cache_bus_arbiter.sv
// Cache-line bus arbiter: round-robin sharing of one memory bus controller
// between N_REQ caches. One transaction is in flight at a time, with stale
// tagging of snooped fills and a watchdog that aborts hung transactions.
module cache_bus_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 512,
  parameter int LINE_OFFS  = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_store,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LINE_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_accept,
  output logic [N_REQ-1:0]            resp_valid,
  input  logic [N_REQ-1:0]            resp_ready,
  output logic [LINE_WIDTH-1:0]       resp_data,
  output logic                        resp_stale,
  output logic [N_REQ-1:0]            store_done,
  output logic                        abort,
  output logic                        dn_valid,
  output logic                        dn_store,
  output logic [ADDR_WIDTH-1:0]       dn_addr,
  output logic [LINE_WIDTH-1:0]       dn_data,
  input  logic                        dn_ready,
  input  logic                        dn_rvalid,
  input  logic [LINE_WIDTH-1:0]       dn_rdata,
  output logic                        dn_rready,
  input  logic                        dn_wdone,
  input  logic                        inval_valid,
  input  logic [ADDR_WIDTH-1:0]       inval_addr
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFFS;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LD,
    DELIVER,
    WAIT_ST
  } state_t;

  state_t                  state, state_n;
  logic [PW-1:0]           rr_ptr;
  logic [N_REQ-1:0]        gnt_oh;
  logic [N_REQ-1:0]        rot;
  logic [N_REQ-1:0]        pick_oh;
  logic                    found;
  int unsigned             offs;
  int unsigned             pick;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LINE_WIDTH-1:0]   sel_data;
  logic                    sel_store;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic                    store_q;
  logic                    stale_q;
  logic [WW-1:0]           wd;
  logic                    busy;
  logic                    timeout;
  logic                    inval_hit;

  assign busy      = (state == ISSUE) || (state == WAIT_LD) || (state == WAIT_ST);
  assign timeout   = busy && (wd == WW'(TIMEOUT));
  assign inval_hit = inval_valid && ((state == ISSUE) || (state == WAIT_LD)) &&
                     (((inval_addr ^ addr_q) & LINE_MASK) == '0);
  assign resp_data = rdata_q;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the
  // first set bit, then map the offset back to a requester index.
  always_comb begin
    rot   = N_REQ'({req_valid, req_valid} >> rr_ptr);
    found = 1'b0;
    offs  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        offs  = k;
      end
    end
    pick      = (32'(rr_ptr) + offs) % N_REQ;
    pick_oh   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_store = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pick_oh[i] = found && (pick == i);
      if (pick_oh[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = req_data[i*LINE_WIDTH +: LINE_WIDTH];
        sel_store = req_store[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and output decode; watchdog expiry overrides any handshake.
  always_comb begin
    state_n    = state;
    req_accept = '0;
    resp_valid = '0;
    resp_stale = 1'b0;
    store_done = '0;
    abort      = 1'b0;
    dn_valid   = 1'b0;
    dn_store   = 1'b0;
    dn_addr    = '0;
    dn_data    = '0;
    dn_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_accept = pick_oh;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (timeout) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          dn_valid = 1'b1;
          dn_store = store_q;
          dn_addr  = addr_q;
          dn_data  = data_q;
          if (dn_ready) state_n = store_q ? WAIT_ST : WAIT_LD;
        end
      end
      WAIT_LD: begin
        if (timeout) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          dn_rready = 1'b1;
          if (dn_rvalid) state_n = DELIVER;
        end
      end
      DELIVER: begin
        resp_valid = gnt_oh;
        resp_stale = stale_q;
        if ((resp_ready & gnt_oh) != '0) state_n = IDLE;
      end
      WAIT_ST: begin
        if (timeout) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (dn_wdone) begin
          store_done = gnt_oh;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant capture, request latches, fill buffer, stale flag and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      gnt_oh  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
      stale_q <= 1'b0;
      rdata_q <= '0;
      wd      <= '0;
    end else begin
      if (state == IDLE && found) begin
        gnt_oh  <= pick_oh;
        addr_q  <= sel_addr;
        data_q  <= sel_data;
        store_q <= sel_store;
        stale_q <= 1'b0;
        rr_ptr  <= PW'((pick + 1) % N_REQ);
      end else if (inval_hit) begin
        stale_q <= 1'b1;
      end
      if (state == IDLE)         wd <= '0;
      else if (busy && !timeout) wd <= wd + 1'b1;
      if (state == WAIT_LD && dn_rvalid && !timeout) rdata_q <= dn_rdata;
    end
  end

endmodule
